// File: rtl/wb_arb_pkg.sv
// Shared definitions for the writeback port arbiter: default address/data
// widths and the fixed source IDs of the writeback requesters.
package wb_arb_pkg;

   localparam int WB_AW  = 5;
   localparam int WB_DW  = 32;
   localparam int WB_IDW = 2;

   localparam int SRC_ALU = 0;
   localparam int SRC_MEM = 1;
   localparam int SRC_MDU = 2;

   typedef logic [WB_IDW-1:0] src_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: picks the first valid requester starting at the
// round-robin pointer, and moves the pointer just past the winner whenever
// the caller reports that the grant was consumed.
module rr_arbiter #(
   parameter int N_REQ = 3,
   parameter int IDW   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req_valid,
   input  logic             advance,
   output logic [N_REQ-1:0] grant,
   output logic [IDW-1:0]   grant_idx,
   output logic             grant_any
);

   logic [IDW-1:0] rr_ptr;
   logic [31:0]    cand;

   // Search rr_ptr, rr_ptr+1, ... (wrapping) for the first valid requester.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = (32'(rr_ptr) + 32'(i)) % 32'(N_REQ);
         if (!grant_any && req_valid[IDW'(cand)]) begin
            grant_any = 1'b1;
            grant_idx = IDW'(cand);
         end
      end
      grant = grant_any ? (N_REQ'(1) << grant_idx) : '0;
   end

   // Pointer moves to the slot after the winner, wrapping at the last source.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (advance) begin
         rr_ptr <= (grant_idx == IDW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the single register-file write port between
// the ALU, load/MEM and MDU writeback sources. One winner per cycle is
// registered onto the write port with one cycle of latency.
// Optional feature macro: WB_ARB_ZERO_FILTER_EN (suppresses writes to r0).
module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int AW    = WB_AW,
   parameter int DW    = WB_DW,
   parameter int IDW   = WB_IDW
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    i_req_valid,
   output logic [N_REQ-1:0]    o_req_ready,
   input  logic [N_REQ*AW-1:0] i_req_wra,
   input  logic [N_REQ*DW-1:0] i_req_wrd,
   input  logic                i_stall,
   output logic                o_wb_regWe,
   output logic [AW-1:0]       o_wb_WRA,
   output logic [DW-1:0]       o_wb_WRD,
   output logic [IDW-1:0]      o_wb_src
);

   logic [N_REQ-1:0] grant;
   logic [IDW-1:0]   grant_idx;
   logic             grant_any;
   logic             xfer;
   logic [AW-1:0]    sel_wra;
   logic [DW-1:0]    sel_wrd;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDW   (IDW)
   ) u_rr_arbiter (
      .clk       (clk),
      .rst       (rst),
      .req_valid (i_req_valid),
      .advance   (xfer),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // Ready is the arbiter grant, masked off while in reset or stalled;
   // it never looks at the payload.
   always_comb begin
      o_req_ready = (rst || i_stall || !grant_any) ? '0 : grant;
      xfer        = |o_req_ready;
   end

   // Route the winning source's address and data toward the output register.
   always_comb begin
      sel_wra = '0;
      sel_wrd = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (grant_idx == IDW'(k)) begin
            sel_wra = i_req_wra[k*AW +: AW];
            sel_wrd = i_req_wrd[k*DW +: DW];
         end
      end
   end

   // Write-port register: load on a handshake, drop the enable when idle,
   // and freeze everything (enable included) while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_wb_regWe <= 1'b0;
         o_wb_WRA   <= '0;
         o_wb_WRD   <= '0;
         o_wb_src   <= IDW'(SRC_ALU);
      end else if (!i_stall) begin
         if (xfer) begin
`ifdef WB_ARB_ZERO_FILTER_EN
            if (sel_wra == '0) begin
               o_wb_regWe <= 1'b0;
               o_wb_WRA   <= '0;
               o_wb_WRD   <= '0;
            end else begin
               o_wb_regWe <= 1'b1;
               o_wb_WRA   <= sel_wra;
               o_wb_WRD   <= sel_wrd;
            end
`else
            o_wb_regWe <= 1'b1;
            o_wb_WRA   <= sel_wra;
            o_wb_WRD   <= sel_wrd;
`endif
            o_wb_src   <= grant_idx;
         end else begin
            o_wb_regWe <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter (N_REQ=3, AW=5, DW=32).
module tb_wb_port_arbiter;

   logic        clk;
   logic        rst;
   logic [2:0]  i_req_valid;
   logic [2:0]  o_req_ready;
   logic [14:0] i_req_wra;
   logic [95:0] i_req_wrd;
   logic        i_stall;
   logic        o_wb_regWe;
   logic [4:0]  o_wb_WRA;
   logic [31:0] o_wb_WRD;
   logic [1:0]  o_wb_src;

   int checks;
   int errors;

   wb_port_arbiter #(
      .N_REQ (3),
      .AW    (5),
      .DW    (32),
      .IDW   (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_req_valid (i_req_valid),
      .o_req_ready (o_req_ready),
      .i_req_wra   (i_req_wra),
      .i_req_wrd   (i_req_wrd),
      .i_stall     (i_stall),
      .o_wb_regWe  (o_wb_regWe),
      .o_wb_WRA    (o_wb_WRA),
      .o_wb_WRD    (o_wb_WRD),
      .o_wb_src    (o_wb_src)
   );

   // Free-running 10-time-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] valid, input logic stall,
                                input logic rstv);
      i_req_valid = valid;
      i_stall     = stall;
      rst         = rstv;
      #1;
   endtask

   task automatic setPayload(input int k, input logic [4:0] a, input logic [31:0] d);
      i_req_wra[k*5 +: 5]   = a;
      i_req_wrd[k*32 +: 32] = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected registered contents for the zero-register write case.
   logic        zeroWe;
   logic [31:0] zeroWrd;

   initial begin
      checks    = 0;
      errors    = 0;
      i_req_wra = '0;
      i_req_wrd = '0;
`ifdef WB_ARB_ZERO_FILTER_EN
      zeroWe  = 1'b0;
      zeroWrd = 32'h0;
`else
      zeroWe  = 1'b1;
      zeroWrd = 32'hFFFF;
`endif

      // Reset with every source requesting: no grant may escape.
      applyStimulus(3'b111, 1'b0, 1'b1);
      checkOutput("rst_ready", 32'(o_req_ready), 32'h0);
      tick();
      tick();
      checkOutput("rst_we", 32'(o_wb_regWe), 32'h0);
      checkOutput("rst_wra", 32'(o_wb_WRA), 32'h0);
      checkOutput("rst_wrd", o_wb_WRD, 32'h0);
      checkOutput("rst_src", 32'(o_wb_src), 32'h0);

      // Single request from source 0, then idle.
      setPayload(0, 5'd5, 32'h1234);
      applyStimulus(3'b001, 1'b0, 1'b0);
      checkOutput("single_ready", 32'(o_req_ready), 32'h1);
      tick();
      applyStimulus(3'b000, 1'b0, 1'b0);
      checkOutput("single_we", 32'(o_wb_regWe), 32'h1);
      checkOutput("single_wra", 32'(o_wb_WRA), 32'h5);
      checkOutput("single_wrd", o_wb_WRD, 32'h1234);
      checkOutput("single_src", 32'(o_wb_src), 32'h0);
      checkOutput("idle_ready", 32'(o_req_ready), 32'h0);
      tick();
      checkOutput("idle_we", 32'(o_wb_regWe), 32'h0);
      checkOutput("idle_wra_hold", 32'(o_wb_WRA), 32'h5);
      checkOutput("idle_wrd_hold", o_wb_WRD, 32'h1234);

      // Re-reset so the pointer starts at 0, then all three valid for 6 cycles.
      applyStimulus(3'b000, 1'b0, 1'b1);
      tick();
      for (int k = 0; k < 3; k++) setPayload(k, 5'(k + 1), 32'hA0 + 32'(k));
      for (int c = 0; c < 6; c++) begin
         applyStimulus(3'b111, 1'b0, 1'b0);
         checkOutput("rot_ready", 32'(o_req_ready), 32'(3'b001 << (c % 3)));
         tick();
         checkOutput("rot_src", 32'(o_wb_src), 32'(c % 3));
         checkOutput("rot_wra", 32'(o_wb_WRA), 32'((c % 3) + 1));
         checkOutput("rot_wrd", o_wb_WRD, 32'hA0 + 32'(c % 3));
      end

      // Pointer is 0: grant source 0 alone, pointer becomes 1.
      applyStimulus(3'b001, 1'b0, 1'b0);
      checkOutput("ptr1_ready", 32'(o_req_ready), 32'h1);
      tick();
      // Sources 0 and 2 valid with pointer 1: source 2 wins, then source 0.
      applyStimulus(3'b101, 1'b0, 1'b0);
      checkOutput("skip_ready_a", 32'(o_req_ready), 32'h4);
      tick();
      checkOutput("skip_src_a", 32'(o_wb_src), 32'h2);
      applyStimulus(3'b101, 1'b0, 1'b0);
      checkOutput("skip_ready_b", 32'(o_req_ready), 32'h1);
      tick();
      checkOutput("skip_src_b", 32'(o_wb_src), 32'h0);
      checkOutput("skip_wra_b", 32'(o_wb_WRA), 32'h1);

      // Stall for 3 cycles with source 1 waiting: everything frozen.
      for (int c = 0; c < 3; c++) begin
         applyStimulus(3'b010, 1'b1, 1'b0);
         checkOutput("stall_ready", 32'(o_req_ready), 32'h0);
         tick();
         checkOutput("stall_we", 32'(o_wb_regWe), 32'h1);
         checkOutput("stall_src", 32'(o_wb_src), 32'h0);
         checkOutput("stall_wrd", o_wb_WRD, 32'hA0);
      end
      applyStimulus(3'b010, 1'b0, 1'b0);
      checkOutput("unstall_ready", 32'(o_req_ready), 32'h2);
      tick();
      checkOutput("unstall_we", 32'(o_wb_regWe), 32'h1);
      checkOutput("unstall_src", 32'(o_wb_src), 32'h1);
      checkOutput("unstall_wra", 32'(o_wb_WRA), 32'h2);
      checkOutput("unstall_wrd", o_wb_WRD, 32'hA1);

      // Reset in mid-operation with all sources valid (pointer was 2).
      applyStimulus(3'b111, 1'b0, 1'b1);
      checkOutput("midrst_ready", 32'(o_req_ready), 32'h0);
      tick();
      checkOutput("midrst_we", 32'(o_wb_regWe), 32'h0);
      checkOutput("midrst_wrd", o_wb_WRD, 32'h0);
      applyStimulus(3'b111, 1'b0, 1'b0);
      checkOutput("postrst_ready", 32'(o_req_ready), 32'h1);
      tick();
      checkOutput("postrst_src", 32'(o_wb_src), 32'h0);
      checkOutput("postrst_wra", 32'(o_wb_WRA), 32'h1);

      // Write targeting r0 from source 0 (only source valid).
      setPayload(0, 5'd0, 32'hFFFF);
      applyStimulus(3'b001, 1'b0, 1'b0);
      checkOutput("r0_ready", 32'(o_req_ready), 32'h1);
      tick();
      applyStimulus(3'b000, 1'b0, 1'b0);
      checkOutput("r0_we", 32'(o_wb_regWe), 32'(zeroWe));
      checkOutput("r0_wra", 32'(o_wb_WRA), 32'h0);
      checkOutput("r0_wrd", o_wb_WRD, zeroWrd);
      checkOutput("r0_src", 32'(o_wb_src), 32'h0);
      tick();
      checkOutput("final_idle_we", 32'(o_wb_regWe), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
